// File: rtl/anita4_bufmgr_pkg.sv
// Shared types and constants for the ANITA-4 trigger buffer manager.
// Buffer state encodings and the digitize-queue entry layout.
package anita4_bufmgr_pkg;

  localparam logic BUFFER_HELD = 1'b1;
  localparam logic BUFFER_FREE = 1'b0;

  // Widest supported fields; an instance uses the low bits.
  localparam int MAX_BUF_W  = 4;
  localparam int MAX_TRIG_W = 16;
  localparam int MAX_EVT_W  = 32;

  typedef struct packed {
    logic [MAX_BUF_W-1:0]  buffer;
    logic [MAX_TRIG_W-1:0] source;
    logic [MAX_EVT_W-1:0]  event_num;
  } dig_entry_t;

endpackage

// File: rtl/anita4_digitize_fifo.sv
// First-word-fall-through digitize queue with same-edge push/pop.
// Ports: clk_i/rst_i; push_i, push_buf_i, push_data_i; pop_i;
//   valid_o, head_buf_o, head_data_o; queued_o (per-buffer mask).
module anita4_digitize_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH),
  parameter int DW    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [IW-1:0]    push_buf_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [IW-1:0]    head_buf_o,
  output logic [DW-1:0]    head_data_o,
  output logic [DEPTH-1:0] queued_o
);

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [IW-1:0]    wr_q, rd_q;
  logic [IW:0]      cnt_q;
  logic [DEPTH-1:0] qmask_q, qmask_d;
  logic [IW-1:0]    buf_mem  [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic             do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  // Each buffer is queued at most once, so a set/clear mask is exact.
  always_comb begin
    qmask_d = qmask_q;
    if (do_pop) qmask_d[buf_mem[rd_q]] = 1'b0;
    if (push_i) qmask_d[push_buf_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      qmask_q <= '0;
    end else begin
      if (push_i) wr_q <= (wr_q == LAST) ? '0 : wr_q + IW'(1);
      if (do_pop) rd_q <= (rd_q == LAST) ? '0 : rd_q + IW'(1);
      unique case ({push_i, do_pop})
        2'b10:   cnt_q <= cnt_q + (IW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (IW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      qmask_q <= qmask_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      buf_mem[wr_q]  <= push_buf_i;
      data_mem[wr_q] <= push_data_i;
    end
  end

  assign valid_o     = (cnt_q != '0);
  assign head_buf_o  = valid_o ? buf_mem[rd_q] : '0;
  assign head_data_o = valid_o ? data_mem[rd_q] : '0;
  assign queued_o    = qmask_q;

endmodule

// File: rtl/anita4_buffer_manager.sv
// Trigger buffer manager: allocates LAB hold buffers, holdoff, digitize queue.
// Ports: clk250_i, rst_i, trig_i/trig_o/trig_buffer_o, clear_*, digitize_*,
//   HOLD_o, dead_o; deadtime_o/deadtime_clr_i with ANITA4_DEADTIME_CNT_EN.
module anita4_buffer_manager #(
  parameter int NUM_HOLD       = 4,
  parameter int BUF_W          = $clog2(NUM_HOLD),
  parameter int NUM_TRIG       = 4,
  parameter int HOLDOFF_CYCLES = 25,
  parameter int EVT_W          = 16
) (
  input  logic                clk250_i,
  input  logic                rst_i,
  input  logic [NUM_TRIG-1:0] trig_i,
  output logic                trig_o,
  output logic [BUF_W-1:0]    trig_buffer_o,
  input  logic                clear_i,
  input  logic [BUF_W-1:0]    clear_buffer_i,
  output logic                clear_err_o,
  output logic                digitize_o,
  input  logic                digitize_ack_i,
  output logic [BUF_W-1:0]    digitize_buffer_o,
  output logic [NUM_TRIG-1:0] digitize_source_o,
  output logic [EVT_W-1:0]    digitize_event_o,
  output logic [NUM_HOLD-1:0] HOLD_o,
`ifdef ANITA4_DEADTIME_CNT_EN
  output logic [31:0]         deadtime_o,
  input  logic                deadtime_clr_i,
`endif
  output logic                dead_o
);

  import anita4_bufmgr_pkg::*;

  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES);
  localparam logic [BUF_W:0] NH = (BUF_W+1)'(NUM_HOLD);
  localparam int DW = NUM_TRIG + EVT_W;

  logic [NUM_HOLD-1:0] hold_q, hold_d;
  logic [BUF_W-1:0]    ptr_q, ptr_d;
  logic [EVT_W-1:0]    evt_q, evt_d;
  logic [HO_W-1:0]     ho_q, ho_d;
  logic                trig_q, trig_d;
  logic [BUF_W-1:0]    tbuf_q, tbuf_d;
  logic                cerr_q, cerr_d;
  logic                dead_q, dead_d;
  logic                pend_q, pend_d;
  logic [BUF_W-1:0]    pbuf_q, pbuf_d;
  logic [DW-1:0]       pdata_q, pdata_d;

  logic                found;
  logic [BUF_W-1:0]    alloc;
  logic [BUF_W:0]      sum;
  logic [BUF_W-1:0]    idx;
  logic [NUM_HOLD-1:0] fifo_queued, pend_mask, queued;
  logic                accept, clr_ok, pop;
  logic                dig_valid;
  logic [DW-1:0]       head_data;

  // Circular first-free search starting at the next pointer.
  always_comb begin
    found = 1'b0;
    alloc = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_HOLD; i++) begin
      sum = {1'b0, ptr_q} + (BUF_W+1)'(i);
      if (sum >= NH) sum = sum - NH;
      idx = sum[BUF_W-1:0];
      if (!found && hold_q[idx] == BUFFER_FREE) begin
        found = 1'b1;
        alloc = idx;
      end
    end
  end

  // An accepted entry waits one cycle before entering the queue;
  // its buffer must still count as queued for clear checks.
  always_comb begin
    pend_mask = '0;
    if (pend_q) pend_mask[pbuf_q] = 1'b1;
  end

  assign queued = fifo_queued | pend_mask;
  assign accept = (|trig_i) && (ho_q == '0) && found;
  assign clr_ok = clear_i
               && ({1'b0, clear_buffer_i} < NH)
               && (hold_q[clear_buffer_i] == BUFFER_HELD)
               && !queued[clear_buffer_i];
  assign pop    = dig_valid && digitize_ack_i;

  always_comb begin
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    evt_d   = evt_q;
    ho_d    = (ho_q == '0) ? '0 : ho_q - HO_W'(1);
    trig_d  = accept;
    tbuf_d  = tbuf_q;
    cerr_d  = clear_i && !clr_ok;
    pend_d  = accept;
    pbuf_d  = alloc;
    pdata_d = {trig_i, evt_q};
    if (clr_ok) hold_d[clear_buffer_i] = BUFFER_FREE;
    if (accept) begin
      hold_d[alloc] = BUFFER_HELD;
      ptr_d  = ({1'b0, alloc} + (BUF_W+1)'(1) >= NH)
             ? '0 : alloc + BUF_W'(1);
      evt_d  = evt_q + EVT_W'(1);
      tbuf_d = alloc;
    end
    // Reload after recovering from dead so the LABs can refill.
    if (accept || (clr_ok && dead_q)) ho_d = HO_LOAD;
    dead_d = &hold_d;
  end

  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      hold_q  <= '0;
      ptr_q   <= '0;
      evt_q   <= '0;
      ho_q    <= '0;
      trig_q  <= 1'b0;
      tbuf_q  <= '0;
      cerr_q  <= 1'b0;
      dead_q  <= 1'b0;
      pend_q  <= 1'b0;
      pbuf_q  <= '0;
      pdata_q <= '0;
    end else begin
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      evt_q   <= evt_d;
      ho_q    <= ho_d;
      trig_q  <= trig_d;
      tbuf_q  <= tbuf_d;
      cerr_q  <= cerr_d;
      dead_q  <= dead_d;
      pend_q  <= pend_d;
      pbuf_q  <= pbuf_d;
      pdata_q <= pdata_d;
    end
  end

  anita4_digitize_fifo #(
    .DEPTH (NUM_HOLD),
    .IW    (BUF_W),
    .DW    (DW)
  ) u_fifo (
    .clk_i       (clk250_i),
    .rst_i       (rst_i),
    .push_i      (pend_q),
    .push_buf_i  (pbuf_q),
    .push_data_i (pdata_q),
    .pop_i       (pop),
    .valid_o     (dig_valid),
    .head_buf_o  (digitize_buffer_o),
    .head_data_o (head_data),
    .queued_o    (fifo_queued)
  );

  assign digitize_o        = dig_valid;
  assign digitize_source_o = head_data[DW-1:EVT_W];
  assign digitize_event_o  = head_data[EVT_W-1:0];
  assign trig_o            = trig_q;
  assign trig_buffer_o     = tbuf_q;
  assign clear_err_o       = cerr_q;
  assign HOLD_o            = hold_q;
  assign dead_o            = dead_q;

`ifdef ANITA4_DEADTIME_CNT_EN
  logic [31:0] dt_q;

  always_ff @(posedge clk250_i) begin
    if (rst_i || deadtime_clr_i) begin
      dt_q <= '0;
    end else if ((dead_q || ho_q != '0) && dt_q != '1) begin
      dt_q <= dt_q + 32'd1;
    end
  end

  assign deadtime_o = dt_q;
`endif

endmodule

// File: tb/tb_anita4_buffer_manager.sv
// Self-checking bench for anita4_buffer_manager.
// Directed scenarios plus random traffic against a queue-based model.
module tb_anita4_buffer_manager;

  import anita4_bufmgr_pkg::*;

  localparam int NH = 4;
  localparam int BW = 2;
  localparam int NT = 4;
  localparam int HO = 25;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NT-1:0] trig_i = '0;
  logic          trig_o;
  logic [BW-1:0] trig_buffer_o;
  logic          clear_i = 1'b0;
  logic [BW-1:0] clear_buffer_i = '0;
  logic          clear_err_o;
  logic          digitize_o;
  logic          digitize_ack_i = 1'b0;
  logic [BW-1:0] digitize_buffer_o;
  logic [NT-1:0] digitize_source_o;
  logic [EW-1:0] digitize_event_o;
  logic [NH-1:0] HOLD_o;
  logic          dead_o;
`ifdef ANITA4_DEADTIME_CNT_EN
  logic [31:0]   deadtime_o;
  logic          deadtime_clr_i = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #2 clk = ~clk;

  anita4_buffer_manager #(
    .NUM_HOLD       (NH),
    .NUM_TRIG       (NT),
    .HOLDOFF_CYCLES (HO),
    .EVT_W          (EW)
  ) dut (
    .clk250_i          (clk),
    .rst_i             (rst_i),
    .trig_i            (trig_i),
    .trig_o            (trig_o),
    .trig_buffer_o     (trig_buffer_o),
    .clear_i           (clear_i),
    .clear_buffer_i    (clear_buffer_i),
    .clear_err_o       (clear_err_o),
    .digitize_o        (digitize_o),
    .digitize_ack_i    (digitize_ack_i),
    .digitize_buffer_o (digitize_buffer_o),
    .digitize_source_o (digitize_source_o),
    .digitize_event_o  (digitize_event_o),
    .HOLD_o            (HOLD_o),
`ifdef ANITA4_DEADTIME_CNT_EN
    .deadtime_o        (deadtime_o),
    .deadtime_clr_i    (deadtime_clr_i),
`endif
    .dead_o            (dead_o)
  );

  // Reference model: held set, rotating pointer, event number,
  // holdoff timer, and a queue whose entries show up one cycle late.
  logic [NH-1:0] m_hold;
  int            m_ptr, m_evt, m_ho, m_tbuf;
  bit            m_trig, m_cerr, pend_v;
  dig_entry_t    pend;
  dig_entry_t    mq[$];

  task automatic model_reset();
    m_hold = '0; m_ptr = 0; m_evt = 0; m_ho = 0; m_tbuf = 0;
    m_trig = 0; m_cerr = 0; pend_v = 0; pend = '0;
    mq.delete();
  endtask

  task automatic model_step();
    bit pop, inq, all_held, ok, acc, fnd;
    int alloc, b;
    if (rst_i) begin
      model_reset();
      return;
    end
    pop = (mq.size() > 0) && digitize_ack_i;
    inq = pend_v && (int'(pend.buffer) == int'(clear_buffer_i));
    foreach (mq[i]) if (int'(mq[i].buffer) == int'(clear_buffer_i)) inq = 1;
    all_held = (m_hold == '1);
    ok = clear_i && (int'(clear_buffer_i) < NH)
         && m_hold[clear_buffer_i] && !inq;
    acc = (trig_i != '0) && (m_ho == 0) && !all_held;
    alloc = 0; fnd = 0;
    for (int i = 0; i < NH; i++) begin
      b = (m_ptr + i) % NH;
      if (!fnd && !m_hold[b]) begin alloc = b; fnd = 1; end
    end
    if (acc || (ok && all_held)) m_ho = HO;
    else if (m_ho > 0) m_ho = m_ho - 1;
    if (ok) m_hold[clear_buffer_i] = 1'b0;
    if (pop) void'(mq.pop_front());
    if (pend_v) mq.push_back(pend);
    pend_v = acc;
    if (acc) begin
      m_hold[alloc] = 1'b1;
      m_ptr = (alloc + 1) % NH;
      pend.buffer = 4'(alloc);
      pend.source = 16'(trig_i);
      pend.event_num = 32'(m_evt);
      m_evt = (m_evt + 1) % (1 << EW);
      m_tbuf = alloc;
    end
    m_trig = acc;
    m_cerr = clear_i && !ok;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; trig_i = '0; clear_i = 1'b0; digitize_ack_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic pulse(input logic [NT-1:0] t);
    trig_i = t;
    tick();
    trig_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    wait_n(2);
    checks++;
    if ({trig_o, trig_buffer_o, clear_err_o, digitize_o, digitize_buffer_o,
         digitize_source_o, digitize_event_o, dead_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs trig=%b tbuf=%0d err=%b dig=%b db=%0d ds=%b de=%0d dead=%b required all 0",
               trig_o, trig_buffer_o, clear_err_o, digitize_o,
               digitize_buffer_o, digitize_source_o, digitize_event_o, dead_o);
    end
    checks++;
    if (HOLD_o !== 4'b0000) begin
      errors++; $display("FAIL reset_hold got %b required 0000", HOLD_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    pulse(4'b0010);
    checks++;
    if (trig_o !== 1'b1 || trig_buffer_o !== 2'd0 || HOLD_o !== 4'b0001) begin
      errors++;
      $display("FAIL single_accept trig=%b buf=%0d hold=%b required 1 0 0001",
               trig_o, trig_buffer_o, HOLD_o);
    end
    checks++;
    if (digitize_o !== 1'b0) begin
      errors++; $display("FAIL single_dig_latency got %b required 0", digitize_o);
    end
    tick();
    checks++;
    if (digitize_o !== 1'b1 || digitize_buffer_o !== 2'd0
        || digitize_source_o !== 4'b0010 || digitize_event_o !== 16'd0) begin
      errors++;
      $display("FAIL single_head dig=%b buf=%0d src=%b evt=%0d required 1 0 0010 0",
               digitize_o, digitize_buffer_o, digitize_source_o, digitize_event_o);
    end
    digitize_ack_i = 1'b1;
    tick();
    digitize_ack_i = 1'b0;
    checks++;
    if (digitize_o !== 1'b0) begin
      errors++; $display("FAIL single_ack_empty got %b required 0", digitize_o);
    end
  endtask

  task automatic test_sustained();
    int n_acc = 0;
    int acyc[8];
    int abuf[8];
    do_reset();
    trig_i = 4'b1111;
    digitize_ack_i = 1'b1;
    for (int n = 0; n < 120; n++) begin
      tick();
      if (trig_o === 1'b1) begin
        if (n_acc < 8) begin acyc[n_acc] = n; abuf[n_acc] = int'(trig_buffer_o); end
        n_acc++;
      end
    end
    checks++;
    if (n_acc != 4) begin
      errors++; $display("FAIL sustained_count got %0d required 4", n_acc);
    end
    for (int i = 0; i < 4 && i < n_acc; i++) begin
      checks++;
      if (acyc[i] != 26 * i || abuf[i] != i) begin
        errors++;
        $display("FAIL sustained_accept%0d cycle=%0d buf=%0d required %0d %0d",
                 i, acyc[i], abuf[i], 26 * i, i);
      end
    end
    checks++;
    if (dead_o !== 1'b1 || HOLD_o !== 4'b1111) begin
      errors++; $display("FAIL sustained_dead dead=%b hold=%b required 1 1111", dead_o, HOLD_o);
    end
  endtask

  task automatic test_dead_recovery();
    int got = -1;
    logic [BW-1:0] gbuf = '0;
    clear_i = 1'b1; clear_buffer_i = 2'd2;
    tick();
    clear_i = 1'b0;
    checks++;
    if (HOLD_o !== 4'b1011 || dead_o !== 1'b0 || clear_err_o !== 1'b0) begin
      errors++;
      $display("FAIL recovery_clear hold=%b dead=%b err=%b required 1011 0 0",
               HOLD_o, dead_o, clear_err_o);
    end
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (got < 0 && trig_o === 1'b1) begin got = n; gbuf = trig_buffer_o; end
    end
    checks++;
    if (got != 26 || gbuf !== 2'd2) begin
      errors++;
      $display("FAIL recovery_accept cycle=%0d buf=%0d required 26 2", got, gbuf);
    end
    trig_i = '0;
  endtask

  task automatic test_skip_held();
    logic [BW-1:0] exp_b [3];
    exp_b[0] = 2'd2; exp_b[1] = 2'd3; exp_b[2] = 2'd0;
    do_reset();
    digitize_ack_i = 1'b1;
    pulse(4'b0001); wait_n(30);
    pulse(4'b0001); wait_n(30);
    clear_i = 1'b1; clear_buffer_i = 2'd0;
    tick();
    clear_i = 1'b0;
    checks++;
    if (HOLD_o !== 4'b0010 || clear_err_o !== 1'b0) begin
      errors++; $display("FAIL skip_clear hold=%b err=%b required 0010 0", HOLD_o, clear_err_o);
    end
    wait_n(2);
    for (int i = 0; i < 3; i++) begin
      pulse(4'b1000);
      checks++;
      if (trig_o !== 1'b1 || trig_buffer_o !== exp_b[i]) begin
        errors++;
        $display("FAIL skip_alloc%0d trig=%b buf=%0d required 1 %0d",
                 i, trig_o, trig_buffer_o, exp_b[i]);
      end
      wait_n(30);
    end
    digitize_ack_i = 1'b0;
  endtask

  task automatic test_invalid_clears();
    do_reset();
    pulse(4'b0001);
    clear_i = 1'b1; clear_buffer_i = 2'd0;
    tick();
    checks++;
    if (clear_err_o !== 1'b1 || HOLD_o !== 4'b0001) begin
      errors++; $display("FAIL clr_pending err=%b hold=%b required 1 0001", clear_err_o, HOLD_o);
    end
    tick();
    checks++;
    if (clear_err_o !== 1'b1 || HOLD_o !== 4'b0001) begin
      errors++; $display("FAIL clr_queued err=%b hold=%b required 1 0001", clear_err_o, HOLD_o);
    end
    clear_buffer_i = 2'd1;
    tick();
    checks++;
    if (clear_err_o !== 1'b1 || HOLD_o !== 4'b0001) begin
      errors++; $display("FAIL clr_free err=%b hold=%b required 1 0001", clear_err_o, HOLD_o);
    end
    clear_i = 1'b0; digitize_ack_i = 1'b1;
    tick();
    digitize_ack_i = 1'b0;
    checks++;
    if (clear_err_o !== 1'b0 || digitize_o !== 1'b0) begin
      errors++; $display("FAIL clr_after_pop err=%b dig=%b required 0 0", clear_err_o, digitize_o);
    end
    clear_i = 1'b1; clear_buffer_i = 2'd0;
    tick();
    clear_i = 1'b0;
    checks++;
    if (clear_err_o !== 1'b0 || HOLD_o !== 4'b0000) begin
      errors++; $display("FAIL clr_valid err=%b hold=%b required 0 0000", clear_err_o, HOLD_o);
    end
  endtask

  task automatic test_reset_mid_queue();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0001); wait_n(30);
    end
    checks++;
    if (digitize_o !== 1'b1 || HOLD_o !== 4'b0111) begin
      errors++; $display("FAIL midq_setup dig=%b hold=%b required 1 0111", digitize_o, HOLD_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if ({trig_o, trig_buffer_o, clear_err_o, digitize_o, digitize_buffer_o,
         digitize_source_o, digitize_event_o, dead_o, HOLD_o} !== '0) begin
      errors++;
      $display("FAIL midq_reset dig=%b hold=%b de=%0d required all 0",
               digitize_o, HOLD_o, digitize_event_o);
    end
    pulse(4'b0100);
    checks++;
    if (trig_o !== 1'b1 || trig_buffer_o !== 2'd0) begin
      errors++; $display("FAIL midq_alloc trig=%b buf=%0d required 1 0", trig_o, trig_buffer_o);
    end
    tick();
    checks++;
    if (digitize_o !== 1'b1 || digitize_event_o !== 16'd0 || digitize_source_o !== 4'b0100) begin
      errors++;
      $display("FAIL midq_event dig=%b evt=%0d src=%b required 1 0 0100",
               digitize_o, digitize_event_o, digitize_source_o);
    end
  endtask

  task automatic test_random();
    dig_entry_t eh;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(0, 599) == 0);
      trig_i = ($urandom_range(0, 7) == 0) ? NT'($urandom_range(1, 15)) : '0;
      clear_i = ($urandom_range(0, 5) == 0);
      clear_buffer_i = BW'($urandom_range(0, NH - 1));
      digitize_ack_i = ($urandom_range(0, 2) == 0);
      tick();
      eh = (mq.size() > 0) ? mq[0] : '0;
      checks++;
      if (trig_o !== m_trig) begin
        errors++; $display("FAIL rnd_trig cyc %0d got %b required %b", n, trig_o, m_trig);
      end
      checks++;
      if (trig_buffer_o !== BW'(m_tbuf)) begin
        errors++; $display("FAIL rnd_tbuf cyc %0d got %0d required %0d", n, trig_buffer_o, m_tbuf);
      end
      checks++;
      if (clear_err_o !== m_cerr) begin
        errors++; $display("FAIL rnd_cerr cyc %0d got %b required %b", n, clear_err_o, m_cerr);
      end
      checks++;
      if (HOLD_o !== m_hold) begin
        errors++; $display("FAIL rnd_hold cyc %0d got %b required %b", n, HOLD_o, m_hold);
      end
      checks++;
      if (dead_o !== (m_hold == '1)) begin
        errors++; $display("FAIL rnd_dead cyc %0d got %b required %b", n, dead_o, m_hold == '1);
      end
      checks++;
      if (digitize_o !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_dig cyc %0d got %b required %b", n, digitize_o, mq.size() > 0);
      end
      checks++;
      if (digitize_buffer_o !== eh.buffer[BW-1:0]) begin
        errors++; $display("FAIL rnd_dbuf cyc %0d got %0d required %0d", n, digitize_buffer_o, eh.buffer);
      end
      checks++;
      if (digitize_source_o !== eh.source[NT-1:0]) begin
        errors++; $display("FAIL rnd_dsrc cyc %0d got %b required %b", n, digitize_source_o, eh.source[NT-1:0]);
      end
      checks++;
      if (digitize_event_o !== eh.event_num[EW-1:0]) begin
        errors++; $display("FAIL rnd_devt cyc %0d got %0d required %0d", n, digitize_event_o, eh.event_num);
      end
    end
    rst_i = 1'b0; trig_i = '0; clear_i = 1'b0; digitize_ack_i = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_sustained();
    test_dead_recovery();
    test_skip_held();
    test_invalid_clears();
    test_reset_mid_queue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/anita4_buffer_manager.md
# anita4_buffer_manager

Parametrised next-generation trigger buffer manager for the SURF/TURF digitizer path. Accepts triggers from NUM_TRIG sources, allocates the next free LAB hold buffer with a circular search that skips still-held buffers, and enforces a programmable post-trigger holdoff. It queues held buffers for digitization behind a valid/ack handshake and frees buffers on readout clear. Sits between trigger logic and the LAB digitizer/readout controller.

## Interface
- NUM_HOLD, 4: number of hold buffers (2..16).
- BUF_W, $clog2(NUM_HOLD): buffer index width (derived).
- NUM_TRIG, 4: trigger source count.
- HOLDOFF_CYCLES, 25: post-trigger holdoff in clocks (100 ns at 250 MHz); must be ≥1.
- EVT_W, 16: event counter width.
- clk250_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- trig_i  in  NUM_TRIG  level trigger requests.
- trig_o  out  1  one-cycle pulse on accepted trigger.
- trig_buffer_o  out  BUF_W  buffer allocated by last accepted trigger.
- clear_i  in  1  free-buffer strobe.
- clear_buffer_i  in  BUF_W  buffer to free.
- clear_err_o  out  1  one-cycle pulse when clear is rejected.
- digitize_o  out  1  queue head valid.
- digitize_ack_i  in  1  pop queue head.
- digitize_buffer_o  out  BUF_W  head buffer index.
- digitize_source_o  out  NUM_TRIG  head trigger source snapshot.
- digitize_event_o  out  EVT_W  head event number.
- HOLD_o  out  NUM_HOLD  per-buffer held flags.
- dead_o  out  1  all buffers held.

## Operation
- Accept at edge k iff |trig_i, holdoff counter == 0, and at least one HOLD_o bit is 0 (pre-edge values).
- Allocation: circular search from next_ptr for the first free buffer, evaluated on pre-edge HOLD_o. next_ptr ← alloc+1 mod NUM_HOLD.
- On accept: set HOLD_o[alloc]; pulse trig_o; trig_buffer_o ← alloc. Push {alloc, trig_i, event_cnt} into the digitize queue. Increment event_cnt, wrapping modulo 2^EVT_W. Load holdoff ← HOLDOFF_CYCLES.
- Holdoff counter decrements each cycle while nonzero. A level-held trig_i therefore gives accepts every HOLDOFF_CYCLES+1 cycles.
- Clear is valid when clear_buffer_i < NUM_HOLD, the buffer is held, and the buffer is not in the digitize queue (queue head included).
  - Valid clear: HOLD_o bit cleared.
  - Invalid clear: state unchanged, clear_err_o pulses.
- Valid clear while dead_o = 1 loads holdoff ← HOLDOFF_CYCLES, giving the LABs time to refill.
- A freed buffer is not eligible for allocation until the edge after the clear. Same-edge clear and accept never pick the cleared buffer.
- Digitize queue: depth NUM_HOLD; it cannot overflow because each entry owns a held buffer. A pop occurs when digitize_o && digitize_ack_i. An ack while empty is ignored. Push and pop may occur on the same edge.
- dead_o = &HOLD_o, registered from next-state.

## Timing
- Reset values: trig_o 0, trig_buffer_o 0, clear_err_o 0, digitize_o 0, digitize_buffer_o/source/event 0, HOLD_o 0, dead_o 0. Internally, next_ptr 0, event_cnt 0, holdoff 0, queue empty.
- A reset asserted mid-operation discards queued events and frees all buffers on the next edge.
- Accept latency: trig_i sampled at edge k. trig_o, trig_buffer_o, HOLD_o and dead_o update at edge k.
- digitize_o rises at edge k+1 if the queue was empty. Head fields are stable while digitize_o=1 and not acked.
- Clear latency: HOLD_o bit and dead_o drop at the edge where clear_i is sampled. clear_err_o pulses at that same edge.

## Configuration
- ANITA4_DEADTIME_CNT_EN defined:
  - Adds ports deadtime_o (out, 32), a saturating count of cycles with dead_o = 1 or holdoff ≠ 0, and deadtime_clr_i (in, 1), a synchronous zero of that count.
  - Reset value of deadtime_o is 0.
- Undefined: both ports and the counter are absent; all other behaviour is identical.

## Structure
- Package anita4_bufmgr_pkg: BUFFER_HELD/BUFFER_FREE constants and a digitize-entry struct typedef {buffer, source, event}.
- Sub-module anita4_digitize_fifo: first-word-fall-through FIFO, parametrised depth/width, with same-edge push/pop. It also provides a per-buffer "queued" bitmask for clear validation.

## Test plan
- Single trigger: trig_i=4'b0010 for 1 cycle after reset -> trig_o pulse, trig_buffer_o=0, HOLD_o=4'b0001. digitize_o with buffer 0, source 4'b0010, event 0; ack empties the queue.
- Sustained trigger, no clears, HOLDOFF_CYCLES=25 -> accepts 26 cycles apart on buffers 0,1,2,3. dead_o=1 after the 4th, and no 5th accept.
- Dead recovery: from dead with the queue drained, clear buffer 2 -> HOLD_o=4'b1011, dead_o=0. The next accept uses buffer 2, no earlier than 26 cycles after the clear.
- Skip held: hold buffers 0,1, clear 0, trigger -> allocation goes to buffer 2, not 0. After 2 and 3, the next goes to 0.
- Invalid clears: clear of a free buffer, and clear of a queued un-acked buffer -> clear_err_o pulse, HOLD_o unchanged.
- Reset mid-queue with 3 entries pending -> all outputs at reset values next cycle. The next trigger gets buffer 0 and event 0.
